instr_packer: RTL and testbench
===============================

Name: instr_packer

Overview:
- Inverse of the instruction field splitter: takes decoded fields (op, rs, rt, rd, shamt, func, imm16, Target) plus a format select.
- Packs each set into a 32-bit MIPS word, buffers it in a small FIFO, and writes it to instruction memory at consecutive word addresses.
- Used by the test/boot path to load programs into IM before the single-cycle core runs.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- BASE, 32'h0000_0000, first IM byte address written after start.
- CW, 16, width of write counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin a load session; honoured only in IDLE.
- in_valid  input  1  field set valid.
- in_ready  output  1  packer can accept.
- in_last  input  1  marks final field set of session.
- fmt  input  2  00=R, 01=I, 10=J, 11=reserved.
- op  input  6  opcode.
- rs  input  5  source reg.
- rt  input  5  target reg.
- rd  input  5  dest reg.
- shamt  input  5  shift amount.
- func  input  6  function code.
- imm16  input  16  immediate.
- Target  input  26  jump target.
- imem_we  output  1  IM write request.
- imem_ready  input  1  IM accepts write this cycle.
- imem_addr  output  32  IM byte address.
- imem_wdata  output  32  packed instruction.
- count  output  CW  words written this session.
- err  output  1  sticky; reserved fmt seen this session.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse at session end.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, FIFO empty, imem_addr=BASE, count=0, err=0, done=0, imem_we=0, in_ready=0, imem_wdata=0.
- States:
  - IDLE: start=1 → LOAD; imem_addr←BASE, count←0, err←0.
  - LOAD: accept = in_valid & in_ready. Accepted with in_last=1 → DRAIN.
  - DRAIN: no accepts. FIFO empty and no write in flight → DONE.
  - DONE: done=1 for exactly this cycle → IDLE.
- in_ready = (state==LOAD) & !full. Full is evaluated before same-cycle pop; no push into a full FIFO even if popping.
- Packing, combinational at accept, stored in FIFO:
  - R: {op,rs,rt,rd,shamt,func}.
  - I: {op,rs,rt,imm16}.
  - J: {op,Target}.
- fmt=11: the handshake still completes, nothing is pushed, err←1. in_last still honoured.
- Write side:
  - imem_we = !empty & (state==LOAD | state==DRAIN).
  - imem_wdata = FIFO head; imem_addr = current address.
  - Write completes when imem_we & imem_ready: pop, imem_addr += 4 (wraps modulo 2^32), count += 1 (saturates at all-ones).
- Latency: a word accepted in cycle N appears on imem_wdata/imem_we no earlier than N+1.
- Simultaneous push and pop (not full): both occur; occupancy unchanged.
- imem_ready low: imem_we, imem_addr and imem_wdata hold stable until accepted.
- start outside IDLE: ignored.
- in_valid outside LOAD: ignored, no state change.
- rst_n asserted mid-session: immediate return to reset values; FIFO contents discarded.
- count and err hold after DONE until the next start.

Test Plan:
- Single R word: start, then fmt=00 addu (op=0, rs=1, rt=2, rd=3, shamt=0, func=0x21), last=1, imem_ready=1 → one write, addr 0x0, data 0x00221821; done pulse; count=1.
- Mixed burst: R addu, then I ori (op=0x0D, rs=0, rt=4, imm=0x1234), then J j (op=2, Target=0x0000C00, last) → writes at 0x0/0x4/0x8 with data 0x00221821 / 0x34041234 / 0x08000C00; count=3; err=0.
- Back-pressure: imem_ready=0 while 5 valid sets are offered → exactly 4 accepted, then in_ready=0; imem_we=1 with addr/data stable; release imem_ready → all 5 written in order, addrs 0x0–0x10.
- Reserved format: sets {R, fmt=11, I(last)} → 2 writes, count=2, err=1 through DONE; next start clears err.
- Reset mid-DRAIN: rst_n=0 with 2 entries queued → imem_we=0, imem_addr=BASE, count=0, busy=0 immediately, no further writes after release.
- Control noise: start pulsed during LOAD and in_valid pulsed in IDLE → no effect on address, count, or FIFO.

Source files
------------

// File: rtl/instr_packer.sv
// instr_packer: packs decoded MIPS fields into 32-bit words, queues them in a
// small FIFO and writes them to instruction memory at consecutive addresses.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin a load session (IDLE only)
//   in_valid/in_ready field-set handshake; in_last marks the final set
//   fmt               00=R, 01=I, 10=J, 11=reserved (flags err, not written)
//   op..Target        decoded instruction fields
//   imem_we/ready     IM write request / IM accepts this cycle
//   imem_addr/wdata   IM byte address / packed instruction (FIFO head)
//   count             words written this session (saturating)
//   err               sticky reserved-format flag for the session
//   busy, done        session active / one-cycle end-of-session pulse
module instr_packer #(
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter int unsigned CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [1:0]    fmt,
    input  logic [5:0]    op,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [5:0]    func,
    input  logic [15:0]   imm16,
    input  logic [25:0]   Target,
    output logic          imem_we,
    input  logic          imem_ready,
    output logic [31:0]   imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [CW-1:0] count,
    output logic          err,
    output logic          busy,
    output logic          done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [31:0]     r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [31:0]     r_addr;
    logic [CW-1:0]   r_count;
    logic            r_err;

    logic            w_full;
    logic            w_empty;
    logic            w_accept;
    logic            w_reserved;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_packed;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) &&
                        (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // Full is judged before any same-cycle pop.
    assign in_ready   = (r_state == S_LOAD) && !w_full;
    assign imem_we    = !w_empty && ((r_state == S_LOAD) || (r_state == S_DRAIN));

    assign w_accept   = in_valid && in_ready;
    assign w_reserved = (fmt == 2'b11);
    assign w_push     = w_accept && !w_reserved;
    assign w_pop      = imem_we && imem_ready;

    assign imem_wdata = r_mem[r_rptr[AW-1:0]];
    assign imem_addr  = r_addr;
    assign count      = r_count;
    assign err        = r_err;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

    // Field packing by format.
    always_comb begin
        w_packed = 32'h0;
        case (fmt)
            2'b00:   w_packed = {op, rs, rt, rd, shamt, func};
            2'b01:   w_packed = {op, rs, rt, imm16};
            2'b10:   w_packed = {op, Target};
            default: w_packed = 32'h0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DRAIN waits for the FIFO to empty since pops are immediate.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_LOAD;
            S_LOAD:  if (w_accept && in_last) w_state_next = S_DRAIN;
            S_DRAIN: if (w_empty) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem  <= '{default: '0};
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= w_packed;
                r_wptr                <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
        end
    end

    // Session address, write count and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= BASE;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_addr  <= BASE;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_addr <= r_addr + 32'd4;
                if (r_count != {CW{1'b1}}) begin
                    r_count <= r_count + CW'(1);
                end
            end
            if (w_accept && w_reserved) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_packer.sv
// Directed bench for instr_packer: drives inputs 1 time unit after the rising
// edge, checks outputs and logs IM writes on the falling edge.
module tb_instr_packer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] imm16;
    logic [25:0] Target;
    logic        imem_we;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [15:0] count;
    logic        err;
    logic        busy;
    logic        done;

    int total;
    int bad;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    instr_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .fmt        (fmt),
        .op         (op),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .func       (func),
        .imm16      (imm16),
        .Target     (Target),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .err        (err),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write the DUT commits on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && imem_we && imem_ready) begin
            wq_addr.push_back(imem_addr);
            wq_data.push_back(imem_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg,
                        input logic l);
        int n;
        fmt = f; op = o; rs = s; rt = t; rd = d; shamt = sh; func = fn;
        imm16 = im; Target = tg; in_last = l; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick;
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_in_ready got=%b want=1", in_ready);
        end
        tick;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_pulse got=%b want=1", done);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 0; in_valid = 0; in_last = 0; fmt = 0; op = 0; rs = 0;
        rt = 0; rd = 0; shamt = 0; func = 0; imm16 = 0; Target = 0; imem_ready = 0;
        repeat (2) @(negedge clk);
        total += 8;
        if (imem_we !== 1'b0)        begin bad++; $display("FAIL rst_we got=%b want=0", imem_we); end
        if (in_ready !== 1'b0)       begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        if (imem_addr !== 32'h0)     begin bad++; $display("FAIL rst_addr got=%h want=0", imem_addr); end
        if (imem_wdata !== 32'h0)    begin bad++; $display("FAIL rst_wdata got=%h want=0", imem_wdata); end
        if (count !== 16'd0)         begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
        if (err !== 1'b0)            begin bad++; $display("FAIL rst_err got=%b want=0", err); end
        if (busy !== 1'b0)           begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        if (done !== 1'b0)           begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single_r;
        wq_addr.delete(); wq_data.delete();
        imem_ready = 1'b1;
        do_start;
        total += 2;
        if (busy !== 1'b1)    begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
        if (imem_we !== 1'b0) begin bad++; $display("FAIL single_we_early got=%b want=0", imem_we); end
        send(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0, 1'b1);
        wait_done;
        total += 4;
        if (wq_addr.size() != 1) begin
            bad++; $display("FAIL single_nwrites got=%0d want=1", wq_addr.size());
        end else begin
            if (wq_addr[0] !== 32'h0)        begin bad++; $display("FAIL single_addr got=%h want=0", wq_addr[0]); end
            if (wq_data[0] !== 32'h00221821) begin bad++; $display("FAIL single_data got=%h want=00221821", wq_data[0]); end
        end
        if (count !== 16'd1) begin bad++; $display("FAIL single_count got=%0d want=1", count); end
        tick;
        total += 3;
        if (done !== 1'b0)   begin bad++; $display("FAIL single_done_width got=%b want=0", done); end
        if (busy !== 1'b0)   begin bad++; $display("FAIL single_idle got=%b want=0", busy); end
        if (count !== 16'd1) begin bad++; $display("FAIL single_count_hold got=%0d want=1", count); end
    endtask

    task automatic test_mixed_burst;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h00221821; exp_d[1] = 32'h34041234; exp_d[2] = 32'h08000C00;
        wq_addr.delete(); wq_data.delete();
        imem_ready = 1'b1;
        do_start;
        total++;
        if (count !== 16'd0) begin bad++; $display("FAIL mixed_count_clear got=%0d want=0", count); end
        send(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0, 1'b0);
        send(2'b01, 6'h0D, 5'd0, 5'd4, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0, 1'b0);
        send(2'b10, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000C00, 1'b1);
        wait_done;
        total++;
        if (wq_addr.size() != 3) begin
            bad++; $display("FAIL mixed_nwrites got=%0d want=3", wq_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total += 2;
                if (wq_addr[i] !== 32'(i * 4)) begin bad++; $display("FAIL mixed_addr%0d got=%h want=%h", i, wq_addr[i], i * 4); end
                if (wq_data[i] !== exp_d[i])   begin bad++; $display("FAIL mixed_data%0d got=%h want=%h", i, wq_data[i], exp_d[i]); end
            end
        end
        total += 2;
        if (count !== 16'd3) begin bad++; $display("FAIL mixed_count got=%0d want=3", count); end
        if (err !== 1'b0)    begin bad++; $display("FAIL mixed_err got=%b want=0", err); end
        tick;
    endtask

    task automatic test_back_pressure;
        logic [31:0] exp_d [5];
        exp_d[0] = 32'h34010001; exp_d[1] = 32'h34020002; exp_d[2] = 32'h34030003;
        exp_d[3] = 32'h34040004; exp_d[4] = 32'h34050005;
        wq_addr.delete(); wq_data.delete();
        imem_ready = 1'b0;
        do_start;
        for (int k = 1; k <= 4; k++) begin
            send(2'b01, 6'h0D, 5'd0, 5'(k), 5'd0, 5'd0, 6'h0, 16'(k), 26'h0, 1'b0);
        end
        fmt = 2'b01; op = 6'h0D; rs = 5'd0; rt = 5'd5; imm16 = 16'd5; in_last = 1'b1;
        in_valid = 1'b1;
        repeat (3) tick;
        total += 5;
        if (in_ready !== 1'b0)         begin bad++; $display("FAIL bp_full got=%b want=0", in_ready); end
        if (imem_we !== 1'b1)          begin bad++; $display("FAIL bp_we got=%b want=1", imem_we); end
        if (imem_addr !== 32'h0)       begin bad++; $display("FAIL bp_addr_hold got=%h want=0", imem_addr); end
        if (imem_wdata !== 32'h34010001) begin bad++; $display("FAIL bp_data_hold got=%h want=34010001", imem_wdata); end
        if (wq_addr.size() != 0)       begin bad++; $display("FAIL bp_nowrite got=%0d want=0", wq_addr.size()); end
        imem_ready = 1'b1;
        send(2'b01, 6'h0D, 5'd0, 5'd5, 5'd0, 5'd0, 6'h0, 16'd5, 26'h0, 1'b1);
        wait_done;
        total++;
        if (wq_addr.size() != 5) begin
            bad++; $display("FAIL bp_nwrites got=%0d want=5", wq_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total += 2;
                if (wq_addr[i] !== 32'(i * 4)) begin bad++; $display("FAIL bp_addr%0d got=%h want=%h", i, wq_addr[i], i * 4); end
                if (wq_data[i] !== exp_d[i])   begin bad++; $display("FAIL bp_data%0d got=%h want=%h", i, wq_data[i], exp_d[i]); end
            end
        end
        total++;
        if (count !== 16'd5) begin bad++; $display("FAIL bp_count got=%0d want=5", count); end
        tick;
    endtask

    task automatic test_reserved_fmt;
        wq_addr.delete(); wq_data.delete();
        imem_ready = 1'b1;
        do_start;
        send(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0, 1'b0);
        send(2'b11, 6'h3F, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL rsv_err_set got=%b want=1", err); end
        send(2'b01, 6'h0D, 5'd0, 5'd4, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0, 1'b1);
        wait_done;
        total += 2;
        if (err !== 1'b1)    begin bad++; $display("FAIL rsv_err_done got=%b want=1", err); end
        if (count !== 16'd2) begin bad++; $display("FAIL rsv_count got=%0d want=2", count); end
        total++;
        if (wq_addr.size() != 2) begin
            bad++; $display("FAIL rsv_nwrites got=%0d want=2", wq_addr.size());
        end else begin
            total += 4;
            if (wq_addr[0] !== 32'h0)        begin bad++; $display("FAIL rsv_addr0 got=%h want=0", wq_addr[0]); end
            if (wq_data[0] !== 32'h00221821) begin bad++; $display("FAIL rsv_data0 got=%h want=00221821", wq_data[0]); end
            if (wq_addr[1] !== 32'h4)        begin bad++; $display("FAIL rsv_addr1 got=%h want=4", wq_addr[1]); end
            if (wq_data[1] !== 32'h34041234) begin bad++; $display("FAIL rsv_data1 got=%h want=34041234", wq_data[1]); end
        end
        tick;
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL rsv_err_hold got=%b want=1", err); end
        do_start;
        total += 2;
        if (err !== 1'b0)    begin bad++; $display("FAIL rsv_err_clear got=%b want=0", err); end
        if (count !== 16'd0) begin bad++; $display("FAIL rsv_count_clear got=%0d want=0", count); end
        send(2'b10, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000C00, 1'b1);
        wait_done;
        tick;
    endtask

    task automatic test_reset_mid_drain;
        wq_addr.delete(); wq_data.delete();
        imem_ready = 1'b0;
        do_start;
        send(2'b01, 6'h0D, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'd1, 26'h0, 1'b0);
        send(2'b01, 6'h0D, 5'd0, 5'd2, 5'd0, 5'd0, 6'h0, 16'd2, 26'h0, 1'b0);
        send(2'b01, 6'h0D, 5'd0, 5'd3, 5'd0, 5'd0, 6'h0, 16'd3, 26'h0, 1'b1);
        imem_ready = 1'b1;
        tick;
        imem_ready = 1'b0;
        total += 4;
        if (imem_addr !== 32'h4)         begin bad++; $display("FAIL mdr_addr got=%h want=4", imem_addr); end
        if (count !== 16'd1)             begin bad++; $display("FAIL mdr_count got=%0d want=1", count); end
        if (imem_we !== 1'b1)            begin bad++; $display("FAIL mdr_we got=%b want=1", imem_we); end
        if (imem_wdata !== 32'h34020002) begin bad++; $display("FAIL mdr_head got=%h want=34020002", imem_wdata); end
        rst_n = 1'b0;
        #1;
        total += 4;
        if (imem_we !== 1'b0)     begin bad++; $display("FAIL mdr_rst_we got=%b want=0", imem_we); end
        if (imem_addr !== 32'h0)  begin bad++; $display("FAIL mdr_rst_addr got=%h want=0", imem_addr); end
        if (count !== 16'd0)      begin bad++; $display("FAIL mdr_rst_count got=%0d want=0", count); end
        if (busy !== 1'b0)        begin bad++; $display("FAIL mdr_rst_busy got=%b want=0", busy); end
        imem_ready = 1'b1;
        tick;
        rst_n = 1'b1;
        wq_addr.delete(); wq_data.delete();
        repeat (8) tick;
        total += 2;
        if (wq_addr.size() != 0) begin bad++; $display("FAIL mdr_nowrite got=%0d want=0", wq_addr.size()); end
        if (imem_we !== 1'b0)    begin bad++; $display("FAIL mdr_we_after got=%b want=0", imem_we); end
    endtask

    task automatic test_control_noise;
        wq_addr.delete(); wq_data.delete();
        imem_ready = 1'b1;
        fmt = 2'b00; op = 6'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd0; func = 6'h21;
        in_last = 1'b1; in_valid = 1'b1;
        repeat (3) tick;
        in_valid = 1'b0; in_last = 1'b0;
        total += 3;
        if (busy !== 1'b0)       begin bad++; $display("FAIL noise_idle_busy got=%b want=0", busy); end
        if (in_ready !== 1'b0)   begin bad++; $display("FAIL noise_idle_ready got=%b want=0", in_ready); end
        if (wq_addr.size() != 0) begin bad++; $display("FAIL noise_idle_write got=%0d want=0", wq_addr.size()); end
        do_start;
        send(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0, 1'b0);
        tick;
        do_start;
        total += 4;
        if (busy !== 1'b1)        begin bad++; $display("FAIL noise_load_busy got=%b want=1", busy); end
        if (in_ready !== 1'b1)    begin bad++; $display("FAIL noise_load_ready got=%b want=1", in_ready); end
        if (imem_addr !== 32'h4)  begin bad++; $display("FAIL noise_addr got=%h want=4", imem_addr); end
        if (count !== 16'd1)      begin bad++; $display("FAIL noise_count got=%0d want=1", count); end
        send(2'b01, 6'h0D, 5'd0, 5'd4, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0, 1'b1);
        wait_done;
        total += 2;
        if (count !== 16'd2) begin bad++; $display("FAIL noise_final_count got=%0d want=2", count); end
        if (wq_addr.size() != 2) begin
            bad++; $display("FAIL noise_nwrites got=%0d want=2", wq_addr.size());
        end else begin
            total += 2;
            if (wq_addr[1] !== 32'h4)        begin bad++; $display("FAIL noise_addr1 got=%h want=4", wq_addr[1]); end
            if (wq_data[1] !== 32'h34041234) begin bad++; $display("FAIL noise_data1 got=%h want=34041234", wq_data[1]); end
        end
        tick;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_single_r;
        test_mixed_burst;
        test_back_pressure;
        test_reserved_fmt;
        test_reset_mid_drain;
        test_control_noise;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
